// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered 8N1 UART transmitter with a valid/ready byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int BIT_RATE   = 9600,
    parameter int CLK_HZ     = 100_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          aresetn_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [7:0]                    s_data_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int c_CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int c_AW           = $clog2(FIFO_DEPTH);
    localparam int c_CW           = $clog2(c_CLKS_PER_BIT);

    localparam logic [c_CW-1:0] c_LAST_CLK = c_CW'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CLK_ONE  = c_CW'(1);
    localparam logic [c_AW:0]   c_FULL     = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [1:0]      r_rst_sync;
    logic            w_rst_n;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [c_AW:0]   w_count_nxt;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_clk_cnt;
    logic [c_CW-1:0] w_clk_cnt_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            r_busy;
    logic            w_push;
    logic            w_pop;
    logic            w_bit_end;
    logic            w_fifo_nempty;

    // Assertion is immediate; release is retimed to clk so no flop sees a runt.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign s_ready_o     = (r_count != c_FULL);
    assign w_push        = s_valid_i && s_ready_o;
    assign w_fifo_nempty = (r_count != '0);
    assign w_bit_end     = (r_clk_cnt == c_LAST_CLK);

    assign tx_o         = r_tx;
    assign busy_o       = r_busy;
    assign fifo_count_o = r_count;
    assign tx_done_o    = (r_state == ST_STOP) && w_bit_end;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data_i;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_fifo_nempty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = r_mem[r_rd_ptr];
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = ST_START;
                    w_tx_nxt      = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = ST_DATA;
                    w_tx_nxt      = r_shift[0];
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CLK_ONE;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CLK_ONE;
                end
            end
            ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (w_fifo_nempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = ST_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CLK_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
            r_count   <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire
